cpstr_wrr_sched: RTL and testbench

- Weighted round-robin scheduler that shares the multiplexed cpstr TX byte path between NUM_STREAMS upstream streams.
- Each stream has a runtime byte quota per burst. The block issues a one-hot grant, counts accepted bytes against the quota, and rotates the grant when the quota is exhausted and a competitor is waiting.
- It also generates a periodic keepalive request that makes the TX path re-emit the current stream index.
- It sits beside the TX mux/escaper; the mux consumes o_grant and the block consumes the mux's byte handshake.

---
 rtl/cpstr_wrr_sched_if.sv | 28 ++
 rtl/cpstr_wrr_sched.sv | 143 ++++++++++++++
 tb/tb_cpstr_wrr_sched.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpstr_wrr_sched_if.sv
// Byte-path arbitration bundle between the upstream streams, the TX mux and
// the weighted round-robin scheduler.
interface cpstr_wrr_sched_if #(
  parameter int NUM_STREAMS = 2,
  parameter int QUOTA_W     = 8
);
  localparam int IDX_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

  logic [NUM_STREAMS-1:0]         i_valid;
  logic [QUOTA_W*NUM_STREAMS-1:0] i_quota;
  logic                           i_xfer;
  logic [NUM_STREAMS-1:0]         o_grant;
  logic [IDX_W-1:0]               o_grant_idx;
  logic                           o_new_grant;
  logic                           o_emit_stridx;

  // Request side: streams and mux drive requests and byte acceptance
  modport master (
    output i_valid, i_quota, i_xfer,
    input  o_grant, o_grant_idx, o_new_grant, o_emit_stridx
  );

  // Scheduler side
  modport slave (
    input  i_valid, i_quota, i_xfer,
    output o_grant, o_grant_idx, o_new_grant, o_emit_stridx
  );
endinterface

// File: rtl/cpstr_wrr_sched.sv
// Weighted round-robin scheduler for the shared cpstr TX byte path.
// Grants one stream at a time, spends a per-stream byte credit, rotates when
// the credit runs out and someone else is waiting, and raises a periodic
// keepalive asking the TX path to re-emit the current stream index.
module cpstr_wrr_sched #(
  parameter int NUM_STREAMS = 2,
  parameter int QUOTA_W     = 8,
  parameter int KEEPALIVE   = 65536
) (
  input  logic               i_clk,
  input  logic               i_rst,
  cpstr_wrr_sched_if.slave   bus
);

  localparam int IDX_W  = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam int KA_W   = (KEEPALIVE > 1) ? $clog2(KEEPALIVE) : 1;
  localparam int KA_MAX = (KEEPALIVE > 0) ? KEEPALIVE - 1 : 0;
  localparam logic [KA_W-1:0] KA_LAST = KA_W'(KA_MAX);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_STREAMS-1:0] grant_q, grant_d;
  logic [QUOTA_W-1:0]     credit_q, credit_d;
  logic [KA_W-1:0]        ka_q, ka_d;
  logic                   new_grant_q, new_grant_d;
  logic                   emit_q, emit_d;

  logic [QUOTA_W-1:0]     quota [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] eligible;
  logic                   found;
  logic [IDX_W-1:0]       pick;
  logic                   other_elig;
  logic                   load, release_g, reload, dec;

  // Unpack quotas, flag eligible streams and search from ptr+1 for the next one
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      quota[k]    = bus.i_quota[QUOTA_W*k +: QUOTA_W];
      eligible[k] = bus.i_valid[k] && (quota[k] != '0);
    end
    for (int i = 1; i <= NUM_STREAMS; i++) begin
      int cand;
      cand = int'(ptr_q) + i;
      if (cand >= NUM_STREAMS) cand = cand - NUM_STREAMS;
      if (!found && eligible[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
    other_elig = |(eligible & ~grant_q);
  end

  // State register plus all datapath flops, cleared asynchronously
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NUM_STREAMS - 1);
      idx_q       <= '0;
      grant_q     <= '0;
      credit_q    <= '0;
      ka_q        <= '0;
      new_grant_q <= 1'b0;
      emit_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      grant_q     <= grant_d;
      credit_q    <= credit_d;
      ka_q        <= ka_d;
      new_grant_q <= new_grant_d;
      emit_q      <= emit_d;
    end
  end

  // Next-state logic; a dropped or disabled stream releases before any credit rule
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    release_g = 1'b0;
    reload    = 1'b0;
    dec       = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          load    = 1'b1;
        end
      end
      GRANT: begin
        if (!eligible[idx_q]) begin
          release_g = 1'b1;
        end else if (bus.i_xfer) begin
          if (credit_q == QUOTA_W'(1)) begin
            if (other_elig) release_g = 1'b1;
            else            reload    = 1'b1;
          end else begin
            dec = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (release_g) state_d = IDLE;
  end

  // Grant, credit and keepalive bookkeeping driven by the chosen transition
  always_comb begin
    grant_d     = grant_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    credit_d    = credit_q;
    ka_d        = ka_q;
    new_grant_d = load;
    if (load) begin
      grant_d  = NUM_STREAMS'(1) << pick;
      idx_d    = pick;
      credit_d = quota[pick];
      ka_d     = '0;
    end else if (release_g) begin
      grant_d  = '0;
      ptr_d    = idx_q;
      credit_d = '0;
      ka_d     = '0;
    end else if (state_q == GRANT) begin
      ka_d = (ka_q == KA_LAST) ? '0 : ka_q + KA_W'(1);
      if (reload) credit_d = quota[idx_q];
      if (dec)    credit_d = credit_q - QUOTA_W'(1);
    end
    emit_d = (KEEPALIVE != 0) && (state_d == GRANT) && (ka_d == KA_LAST);
  end

  assign bus.o_grant       = grant_q;
  assign bus.o_grant_idx   = idx_q;
  assign bus.o_new_grant   = new_grant_q;
  assign bus.o_emit_stridx = emit_q;

endmodule

// File: tb/tb_cpstr_wrr_sched.sv
// Self-checking bench for cpstr_wrr_sched: vector table, directed corner
// sequences and randomized traffic against a burst-level reference model.
module tb_cpstr_wrr_sched;

  localparam int N  = 2;
  localparam int QW = 8;
  localparam int KA = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpstr_wrr_sched_if #(.NUM_STREAMS(N), .QUOTA_W(QW)) bus ();
  cpstr_wrr_sched_if #(.NUM_STREAMS(N), .QUOTA_W(QW)) bus_z ();

  assign bus_z.i_valid = bus.i_valid;
  assign bus_z.i_quota = bus.i_quota;
  assign bus_z.i_xfer  = bus.i_xfer;

  cpstr_wrr_sched #(.NUM_STREAMS(N), .QUOTA_W(QW), .KEEPALIVE(KA)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  cpstr_wrr_sched #(.NUM_STREAMS(N), .QUOTA_W(QW), .KEEPALIVE(0)) dut_z (
    .i_clk(clk), .i_rst(rst), .bus(bus_z)
  );

  int errors = 0;
  int checks = 0;
  int z_emits = 0;

  // Keepalive-disabled instance must never pulse
  always @(negedge clk) if (bus_z.o_emit_stridx) z_emits++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input int q0, input int q1, input logic x);
    bus.i_valid = v;
    bus.i_quota = {QW'(q1), QW'(q0)};
    bus.i_xfer  = x;
  endtask

  task automatic checkOutput(input string nm, input logic [1:0] eg, input int ei,
                             input logic en, input logic ee);
    check({nm, " grant"}, 32'(bus.o_grant), 32'(eg));
    check({nm, " idx"},   32'(bus.o_grant_idx), 32'(ei));
    check({nm, " new"},   32'(bus.o_new_grant), 32'(en));
    check({nm, " emit"},  32'(bus.o_emit_stridx), 32'(ee));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(2'b00, 0, 0, 1'b0);
    #12;
    checkOutput("reset", 2'b00, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference model (burst level) ----------------
  int   m_busy, m_g, m_ptr, m_left, m_age, m_idx;
  logic m_new, m_emit;
  logic [1:0] m_grant;

  function automatic int quotaOf(int k);
    return int'(bus.i_quota[QW*k +: QW]);
  endfunction

  function automatic bit eligOf(int k);
    return bus.i_valid[k] && (quotaOf(k) != 0);
  endfunction

  task automatic modelReset();
    m_busy = 0; m_g = 0; m_ptr = N - 1; m_left = 0; m_age = 0; m_idx = 0;
    m_new = 0; m_emit = 0; m_grant = '0;
  endtask

  // Predicts the outputs visible after the coming clock edge
  task automatic modelStep();
    bit others;
    m_new  = 0;
    m_emit = 0;
    if (m_busy == 0) begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (m_busy == 0 && eligOf(c)) begin
          m_busy = 1; m_g = c; m_idx = c; m_left = quotaOf(c);
          m_age = 1; m_new = 1;
        end
      end
    end else begin
      others = 0;
      for (int j = 0; j < N; j++) if (j != m_g && eligOf(j)) others = 1;
      if (!eligOf(m_g)) begin
        m_busy = 0; m_ptr = m_g;
      end else if (bus.i_xfer) begin
        if (m_left == 1) begin
          if (others) begin m_busy = 0; m_ptr = m_g; end
          else m_left = quotaOf(m_g);
        end else begin
          m_left = m_left - 1;
        end
      end
      if (m_busy != 0) m_age++;
    end
    if (m_busy != 0) m_emit = ((m_age % KA) == 0);
    m_grant = (m_busy != 0) ? 2'(1 << m_g) : 2'b00;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] valid;
    int         q0;
    int         q1;
    logic       xfer;
    logic [1:0] eg;
    int         eidx;
    logic       enew;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt, bad, news, emits, waited;
    logic [1:0] prev;
    int b_s[$];
    int b_n[$];
    int cur_len, cur_s;
    int q0, q1;
    logic [1:0] v;
    logic x;

    vecs[0]  = '{2'b11, 4, 4, 1'b0, 2'b01, 0, 1'b1};
    vecs[1]  = '{2'b11, 4, 4, 1'b1, 2'b01, 0, 1'b0};
    vecs[2]  = '{2'b11, 4, 4, 1'b1, 2'b01, 0, 1'b0};
    vecs[3]  = '{2'b11, 4, 4, 1'b1, 2'b01, 0, 1'b0};
    vecs[4]  = '{2'b11, 4, 4, 1'b1, 2'b00, 0, 1'b0};
    vecs[5]  = '{2'b11, 4, 4, 1'b1, 2'b10, 1, 1'b1};
    vecs[6]  = '{2'b11, 4, 4, 1'b1, 2'b10, 1, 1'b0};
    vecs[7]  = '{2'b01, 4, 4, 1'b1, 2'b00, 1, 1'b0};
    vecs[8]  = '{2'b01, 4, 4, 1'b0, 2'b01, 0, 1'b1};
    vecs[9]  = '{2'b11, 4, 4, 1'b1, 2'b01, 0, 1'b0};
    vecs[10] = '{2'b10, 4, 4, 1'b1, 2'b00, 0, 1'b0};
    vecs[11] = '{2'b10, 4, 4, 1'b0, 2'b10, 1, 1'b1};
    vecs[12] = '{2'b10, 4, 0, 1'b0, 2'b00, 1, 1'b0};
    vecs[13] = '{2'b10, 4, 0, 1'b0, 2'b00, 1, 1'b0};

    applyStimulus(2'b00, 0, 0, 1'b0);
    doReset();

    // Table: rotation with quota 4, drops with xfer, disable via quota 0
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].q0, vecs[i].q1, vecs[i].xfer);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].eg, vecs[i].eidx, vecs[i].enew, 1'b0);
    end

    // Quotas 3/1: bursts of 3,1,3,1 bytes
    doReset();
    applyStimulus(2'b11, 3, 1, 1'b1);
    prev = '0; cur_len = 0; cur_s = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bus.o_grant != 2'b00) begin
        if (bus.o_grant == prev) cur_len++;
        else begin
          if (cur_len > 0) begin b_s.push_back(cur_s); b_n.push_back(cur_len); end
          cur_len = 1; cur_s = int'(bus.o_grant_idx);
        end
      end else if (cur_len > 0) begin
        b_s.push_back(cur_s); b_n.push_back(cur_len); cur_len = 0;
      end
      prev = bus.o_grant;
    end
    check("burst count>=4", 32'(b_s.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < b_s.size(); i++) begin
      check($sformatf("burst%0d stream", i), 32'(b_s[i]), 32'(i % 2));
      check($sformatf("burst%0d bytes", i), 32'(b_n[i]), (i % 2 == 0) ? 32'd3 : 32'd1);
    end

    // Quota1 -> 0: stream 0 keeps the grant, reloading silently
    applyStimulus(2'b11, 3, 0, 1'b1);
    waited = 0;
    while (bus.o_grant != 2'b01 && waited < 10) begin tick(); waited++; end
    check("q1=0 stream0 granted in time", 32'(bus.o_grant), 32'h1);
    bad = 0; news = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.o_grant != 2'b01) bad++;
      if (bus.o_new_grant) news++;
    end
    check("q1=0 hold grant", 32'(bad), 32'd0);
    check("q1=0 no new_grant", 32'(news), 32'd0);

    // Lone stream 1, quota 2: ten bytes in a single grant, then contention
    doReset();
    applyStimulus(2'b10, 2, 2, 1'b1);
    tick();
    checkOutput("lone1 first", 2'b10, 1, 1'b1, 1'b0);
    bad = 0; news = 0;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (bus.o_grant != 2'b10) bad++;
      if (bus.o_new_grant) news++;
    end
    check("lone1 hold", 32'(bad), 32'd0);
    check("lone1 single new_grant", 32'(news), 32'd0);
    applyStimulus(2'b11, 2, 2, 1'b1);
    cnt = 0; waited = 0;
    tick();
    while (bus.o_grant != 2'b00 && waited < 4) begin cnt++; tick(); waited++; end
    check("contend release", 32'(bus.o_grant), 32'h0);
    check("contend bytes<=2", 32'(cnt <= 2), 32'd1);
    tick();
    checkOutput("contend grant0", 2'b01, 0, 1'b1, 1'b0);

    // Keepalive every 8 grant cycles on an unbroken grant
    doReset();
    bad = 0; emits = 0;
    for (int n = 1; n <= 30; n++) begin
      applyStimulus(2'b01, 3, 0, 1'($urandom_range(0, 1)));
      tick();
      if (bus.o_grant != 2'b01) bad++;
      if (bus.o_emit_stridx !== ((n % KA) == 0)) bad++;
      if (bus.o_emit_stridx) emits++;
    end
    check("keepalive pattern errors", 32'(bad), 32'd0);
    check("keepalive pulse count", 32'(emits), 32'd3);

    // Asynchronous reset in the middle of a burst
    doReset();
    applyStimulus(2'b11, 4, 4, 1'b1);
    tick();
    tick();
    check("pre-reset granted", 32'(bus.o_grant), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset", 2'b00, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("post reset grant", 2'b01, 0, 1'b1, 1'b0);

    // Randomized traffic against the reference model
    doReset();
    modelReset();
    q0 = 3; q1 = 2;
    for (int c = 0; c < 600; c++) begin
      int mode;
      mode = (c / 60) % 3;
      if ($urandom_range(0, 15) == 0) q0 = int'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) q1 = int'($urandom_range(0, 5));
      case (mode)
        0: v = {1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0)};
        1: v = {1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) != 0)};
        default: v = {1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 19) == 0)};
      endcase
      x = 1'($urandom_range(0, 9) < 7);
      applyStimulus(v, q0, q1, x);
      modelStep();
      tick();
      checkOutput($sformatf("rnd%0d", c), m_grant, m_idx, m_new, m_emit);
    end

    check("keepalive=0 never pulses", 32'(z_emits), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
